// File: rtl/hdmi_audio_pkg.sv
// Shared constants and helpers for the HDMI audio sample bridge.
package hdmi_audio_pkg;

  localparam int unsigned UR_ZERO = 0;
  localparam int unsigned UR_HOLD = 1;

  // 48 kHz audio from a 25.2 MHz pixel clock; the increment is twice the audio rate.
  localparam int unsigned DEFAULT_RATE_NUM = 96000;
  localparam int unsigned DEFAULT_RATE_DEN = 25200000;

  function automatic int unsigned acc_width(input int unsigned num, input int unsigned den);
    return $clog2(den + num);
  endfunction

endpackage

// File: rtl/hdmi_audio_phase_acc.sv
// Fractional tick generator: tick averages NUM/DEN per clock, with no long-term drift.
module hdmi_audio_phase_acc
  import hdmi_audio_pkg::*;
#(
  parameter int unsigned NUM = DEFAULT_RATE_NUM,
  parameter int unsigned DEN = DEFAULT_RATE_DEN
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned W = acc_width(NUM, DEN);
  localparam logic [W-1:0] NumW = W'(NUM);
  localparam logic [W-1:0] DenW = W'(DEN);

  if (NUM >= DEN) begin : g_bad_rate
    $error("hdmi_audio_phase_acc: NUM must be smaller than DEN");
  end

  logic [W-1:0] acc_q, acc_d, sum;

  always_comb begin
    sum   = acc_q + NumW;
    tick  = (sum >= DenW);
    acc_d = tick ? (sum - DenW) : sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/hdmi_audio_sample_bridge.sv
// PCM frame FIFO, fractional clk_audio generation and width conversion for the HDMI core.
// Optional HDMI_AUDIO_ATTEN_EN adds a per-pop arithmetic attenuation input atten_shift.
module hdmi_audio_sample_bridge
  import hdmi_audio_pkg::*;
#(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned IN_WIDTH      = 16,
  parameter int unsigned OUT_WIDTH     = 16,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned RATE_NUM      = DEFAULT_RATE_NUM,
  parameter int unsigned RATE_DEN      = DEFAULT_RATE_DEN,
  parameter int unsigned UNDERRUN_HOLD = UR_HOLD
) (
  input  logic                          clk_pixel,
  input  logic                          reset_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0]  s_data,
`ifdef HDMI_AUDIO_ATTEN_EN
  input  logic [2:0]                    atten_shift,
`endif
  output logic [CHANNELS*OUT_WIDTH-1:0] audio_word,
  output logic                          clk_audio,
  output logic                          sample_stb,
  output logic [$clog2(DEPTH):0]        fifo_level,
  output logic                          underrun,
  input  logic                          clr_flags
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned IW   = CHANNELS * IN_WIDTH;
  localparam int unsigned OW   = CHANNELS * OUT_WIDTH;
  localparam logic [LvlW-1:0] Full = LvlW'(DEPTH);

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("hdmi_audio_sample_bridge: CHANNELS must be 1..8");
  end
  if (OUT_WIDTH < 16 || OUT_WIDTH > 24) begin : g_bad_out_width
    $error("hdmi_audio_sample_bridge: OUT_WIDTH must be 16..24");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hdmi_audio_sample_bridge: DEPTH must be a power of two >= 2");
  end
  if (UNDERRUN_HOLD > 1) begin : g_bad_hold
    $error("hdmi_audio_sample_bridge: UNDERRUN_HOLD must be 0 or 1");
  end

  logic [IW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            clk_audio_q, clk_audio_d;
  logic            sample_stb_q, sample_stb_d;
  logic            underrun_q, underrun_d;
  logic [OW-1:0]   audio_word_q, audio_word_d;

  logic          tick;
  logic          pop_tick;
  logic          empty;
  logic          push;
  logic          pop;
  logic [IW-1:0] head;
  logic [OW-1:0] conv_word;

  hdmi_audio_phase_acc #(
    .NUM (RATE_NUM),
    .DEN (RATE_DEN)
  ) u_phase_acc (
    .clk   (clk_pixel),
    .rst_n (reset_n),
    .tick  (tick)
  );

  // Pops happen on the falling clk_audio edge so the word is stable for the next rising edge.
  assign pop_tick = tick & clk_audio_q;
  assign empty    = (level_q == '0);
  assign s_ready  = (level_q != Full);
  assign push     = s_valid & s_ready;
  assign pop      = pop_tick & ~empty;
  assign head     = mem_q[rd_ptr_q];

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic signed [IN_WIDTH-1:0]  in_ch;
    logic signed [OUT_WIDTH-1:0] cv;

    assign in_ch = head[ch*IN_WIDTH +: IN_WIDTH];

    if (OUT_WIDTH > IN_WIDTH) begin : g_widen
      assign cv = {in_ch, {(OUT_WIDTH - IN_WIDTH){1'b0}}};
    end else if (OUT_WIDTH == IN_WIDTH) begin : g_same
      assign cv = in_ch;
    end else begin : g_narrow
      localparam int unsigned Drop = IN_WIDTH - OUT_WIDTH;
      assign cv = OUT_WIDTH'(in_ch >>> Drop);
    end

`ifdef HDMI_AUDIO_ATTEN_EN
    assign conv_word[ch*OUT_WIDTH +: OUT_WIDTH] = cv >>> atten_shift;
`else
    assign conv_word[ch*OUT_WIDTH +: OUT_WIDTH] = cv;
`endif
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    audio_word_d = audio_word_q;
    underrun_d   = underrun_q;
    clk_audio_d  = clk_audio_q ^ tick;
    sample_stb_d = pop_tick;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PtrW'(1);
      audio_word_d = conv_word;
    end else if (pop_tick && UNDERRUN_HOLD == UR_ZERO) begin
      audio_word_d = '0;
    end

    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end

    // A fresh underrun beats a simultaneous clear.
    if (pop_tick && empty) begin
      underrun_d = 1'b1;
    end else if (clr_flags) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '{default: '0};
    end else if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      audio_word_q <= '0;
      underrun_q   <= 1'b0;
      clk_audio_q  <= 1'b0;
      sample_stb_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      audio_word_q <= audio_word_d;
      underrun_q   <= underrun_d;
      clk_audio_q  <= clk_audio_d;
      sample_stb_q <= sample_stb_d;
    end
  end

  assign audio_word = audio_word_q;
  assign clk_audio  = clk_audio_q;
  assign sample_stb = sample_stb_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_hdmi_audio_sample_bridge.sv
// Directed bench for hdmi_audio_sample_bridge across several parameter sets.
module tb_hdmi_audio_sample_bridge;

  logic        clk_pixel = 1'b0;
  logic        reset_n;
  logic        s_valid;
  logic [31:0] s_data;
  logic        clr_flags;
`ifdef HDMI_AUDIO_ATTEN_EN
  logic [2:0]  atten_shift;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_pixel = ~clk_pixel;

  // u_def: default rates; u_fifo: slow pops; u_zero: fast pops, zero on underrun.
  logic        d_ready, d_clk, d_stb, d_underrun;
  logic [31:0] d_word;
  logic [3:0]  d_level;
  logic        f_ready, f_clk, f_stb, f_underrun;
  logic [31:0] f_word;
  logic [3:0]  f_level;
  logic        z_ready, z_clk, z_stb, z_underrun;
  logic [31:0] z_word;
  logic [3:0]  z_level;
  logic        w_ready, w_clk, w_stb, w_underrun;
  logic [47:0] w_word;
  logic [3:0]  w_level;
  logic        n_ready, n_clk, n_stb, n_underrun;
  logic [15:0] n_word;
  logic [3:0]  n_level;

  hdmi_audio_sample_bridge u_def (
    .clk_pixel (clk_pixel), .reset_n (reset_n), .s_valid (s_valid), .s_ready (d_ready),
    .s_data (s_data),
`ifdef HDMI_AUDIO_ATTEN_EN
    .atten_shift (atten_shift),
`endif
    .audio_word (d_word), .clk_audio (d_clk), .sample_stb (d_stb), .fifo_level (d_level),
    .underrun (d_underrun), .clr_flags (clr_flags)
  );

  hdmi_audio_sample_bridge #(
    .DEPTH (8), .RATE_NUM (1), .RATE_DEN (64), .UNDERRUN_HOLD (1)
  ) u_fifo (
    .clk_pixel (clk_pixel), .reset_n (reset_n), .s_valid (s_valid), .s_ready (f_ready),
    .s_data (s_data),
`ifdef HDMI_AUDIO_ATTEN_EN
    .atten_shift (atten_shift),
`endif
    .audio_word (f_word), .clk_audio (f_clk), .sample_stb (f_stb), .fifo_level (f_level),
    .underrun (f_underrun), .clr_flags (clr_flags)
  );

  hdmi_audio_sample_bridge #(
    .RATE_NUM (1), .RATE_DEN (4), .UNDERRUN_HOLD (0)
  ) u_zero (
    .clk_pixel (clk_pixel), .reset_n (reset_n), .s_valid (s_valid), .s_ready (z_ready),
    .s_data (s_data),
`ifdef HDMI_AUDIO_ATTEN_EN
    .atten_shift (atten_shift),
`endif
    .audio_word (z_word), .clk_audio (z_clk), .sample_stb (z_stb), .fifo_level (z_level),
    .underrun (z_underrun), .clr_flags (clr_flags)
  );

  hdmi_audio_sample_bridge #(
    .IN_WIDTH (16), .OUT_WIDTH (24), .RATE_NUM (1), .RATE_DEN (4)
  ) u_wide (
    .clk_pixel (clk_pixel), .reset_n (reset_n), .s_valid (s_valid), .s_ready (w_ready),
    .s_data (s_data),
`ifdef HDMI_AUDIO_ATTEN_EN
    .atten_shift (atten_shift),
`endif
    .audio_word (w_word), .clk_audio (w_clk), .sample_stb (w_stb), .fifo_level (w_level),
    .underrun (w_underrun), .clr_flags (clr_flags)
  );

  hdmi_audio_sample_bridge #(
    .CHANNELS (1), .IN_WIDTH (24), .OUT_WIDTH (16), .RATE_NUM (1), .RATE_DEN (4)
  ) u_narrow (
    .clk_pixel (clk_pixel), .reset_n (reset_n), .s_valid (s_valid), .s_ready (n_ready),
    .s_data (s_data[23:0]),
`ifdef HDMI_AUDIO_ATTEN_EN
    .atten_shift (atten_shift),
`endif
    .audio_word (n_word), .clk_audio (n_clk), .sample_stb (n_stb), .fifo_level (n_level),
    .underrun (n_underrun), .clr_flags (clr_flags)
  );

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  // Release lands 1 time unit after an edge, so the next posedge is cycle 1.
  task automatic apply_reset();
    reset_n   = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    clr_flags = 1'b0;
    repeat (2) @(posedge clk_pixel);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_stb(input int which, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      case (which)
        0:       found = d_stb;
        1:       found = f_stb;
        2:       found = z_stb;
        default: found = w_stb;
      endcase
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({d_clk, d_stb, d_underrun, d_ready, d_level} !== 8'b0001_0000 || d_word !== 32'h0)
      $display("FAIL reset_def: got %b/%h expected 00010000/0",
               {d_clk, d_stb, d_underrun, d_ready, d_level}, d_word);
    else n_pass++;
    n_total++;
    if ({f_clk, f_stb, f_underrun, f_ready, f_level} !== 8'b0001_0000 || f_word !== 32'h0)
      $display("FAIL reset_fifo: got %b/%h expected 00010000/0",
               {f_clk, f_stb, f_underrun, f_ready, f_level}, f_word);
    else n_pass++;
    n_total++;
    if ({z_clk, z_stb, z_underrun, z_ready, z_level} !== 8'b0001_0000 || z_word !== 32'h0)
      $display("FAIL reset_zero: got %b/%h expected 00010000/0",
               {z_clk, z_stb, z_underrun, z_ready, z_level}, z_word);
    else n_pass++;
    n_total++;
    if ({w_clk, w_stb, w_underrun, w_ready, w_level} !== 8'b0001_0000 || w_word !== 48'h0)
      $display("FAIL reset_wide: got %b/%h expected 00010000/0",
               {w_clk, w_stb, w_underrun, w_ready, w_level}, w_word);
    else n_pass++;
    n_total++;
    if ({n_clk, n_stb, n_underrun, n_ready, n_level} !== 8'b0001_0000 || n_word !== 16'h0)
      $display("FAIL reset_narrow: got %b/%h expected 00010000/0",
               {n_clk, n_stb, n_underrun, n_ready, n_level}, n_word);
    else n_pass++;
  endtask

  task automatic test_rate();
    int   nr = 0, nf = 0, ns = 0, bad = 0;
    int   last_edge = 0, prev_sp = 0, first_edge = 0, rise0 = 0, rise40 = 0;
    logic prev;
    apply_reset();
    s_valid = 1'b1;
    prev    = d_clk;
    for (int cyc = 1; cyc <= 22000 && nr < 41; cyc++) begin
      s_data = 32'(cyc);
      step();
      if (d_stb) ns++;
      if (d_clk !== prev) begin
        if (last_edge == 0) first_edge = cyc;
        else begin
          if (!((cyc - last_edge == 262 || cyc - last_edge == 263) && cyc - last_edge != prev_sp))
            bad++;
          prev_sp = cyc - last_edge;
        end
        last_edge = cyc;
        if (d_clk) begin
          if (nr == 0) rise0 = cyc;
          if (nr == 40) rise40 = cyc;
          nr++;
        end else nf++;
      end
      prev = d_clk;
    end
    s_valid = 1'b0;
    n_total++;
    if (nr != 41) $display("FAIL rate_timeout: got %0d rising edges expected 41", nr);
    else n_pass++;
    n_total++;
    if (first_edge != 263) $display("FAIL rate_first_edge: got cycle %0d expected 263", first_edge);
    else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL rate_spacing: got %0d bad spacings expected 0", bad);
    else n_pass++;
    n_total++;
    if (rise40 - rise0 != 21000)
      $display("FAIL rate_period: got %0d cycles for 40 periods expected 21000", rise40 - rise0);
    else n_pass++;
    n_total++;
    if (nf != 40 || ns != nf)
      $display("FAIL rate_stb_count: got falls=%0d stb=%0d expected 40/40", nf, ns);
    else n_pass++;
    n_total++;
    if (d_underrun !== 1'b0) $display("FAIL rate_underrun: got %b expected 0", d_underrun);
    else n_pass++;
  endtask

  task automatic test_fifo_full();
    bit found;
    apply_reset();
    s_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      s_data = 32'h1000_0000 + 32'(k);
      step();
    end
    n_total++;
    if (f_level !== 4'd8 || f_ready !== 1'b0)
      $display("FAIL full_level: got level=%0d ready=%b expected 8/0", f_level, f_ready);
    else n_pass++;
    s_data = 32'h9999_0009;
    repeat (3) step();
    n_total++;
    if (f_level !== 4'd8) $display("FAIL full_refuse: got level=%0d expected 8", f_level);
    else n_pass++;
    wait_stb(1, 200, found);
    n_total++;
    if (!found) $display("FAIL full_pop_timeout: got no sample_stb expected one");
    else n_pass++;
    n_total++;
    if (f_level !== 4'd7 || f_word !== 32'h1000_0001 || f_clk !== 1'b0)
      $display("FAIL full_pop: got level=%0d word=%h clk=%b expected 7/10000001/0",
               f_level, f_word, f_clk);
    else n_pass++;
    step();
    s_valid = 1'b0;
    n_total++;
    if (f_level !== 4'd8 || f_ready !== 1'b0)
      $display("FAIL full_refill: got level=%0d ready=%b expected 8/0", f_level, f_ready);
    else n_pass++;
  endtask

  task automatic test_underrun();
    bit found;
    apply_reset();
    s_valid = 1'b1;
    s_data  = 32'h1234_ABCD;
    step();
    s_valid = 1'b0;
    wait_stb(1, 200, found);
    n_total++;
    if (!found || f_word !== 32'h1234_ABCD || f_underrun !== 1'b0 || f_level !== 4'd0)
      $display("FAIL hold_first_pop: got found=%b word=%h ur=%b level=%0d expected 1/1234abcd/0/0",
               found, f_word, f_underrun, f_level);
    else n_pass++;
    wait_stb(1, 200, found);
    n_total++;
    if (!found || f_word !== 32'h1234_ABCD || f_underrun !== 1'b1)
      $display("FAIL hold_underrun: got found=%b word=%h ur=%b expected 1/1234abcd/1",
               found, f_word, f_underrun);
    else n_pass++;
    clr_flags = 1'b1;
    step();
    n_total++;
    if (f_underrun !== 1'b0) $display("FAIL clr_flags: got %b expected 0", f_underrun);
    else n_pass++;
    wait_stb(1, 200, found);
    n_total++;
    if (!found || f_underrun !== 1'b1)
      $display("FAIL clr_vs_event: got found=%b ur=%b expected 1/1", found, f_underrun);
    else n_pass++;
    step();
    clr_flags = 1'b0;
    n_total++;
    if (f_underrun !== 1'b0) $display("FAIL clr_after_event: got %b expected 0", f_underrun);
    else n_pass++;

    apply_reset();
    s_valid = 1'b1;
    s_data  = 32'h1234_ABCD;
    step();
    s_valid = 1'b0;
    wait_stb(2, 40, found);
    n_total++;
    if (!found || z_word !== 32'h1234_ABCD)
      $display("FAIL zero_first_pop: got found=%b word=%h expected 1/1234abcd", found, z_word);
    else n_pass++;
    wait_stb(2, 40, found);
    n_total++;
    if (!found || z_word !== 32'h0 || z_underrun !== 1'b1)
      $display("FAIL zero_underrun: got found=%b word=%h ur=%b expected 1/0/1",
               found, z_word, z_underrun);
    else n_pass++;
  endtask

  task automatic test_width();
    bit found;
    apply_reset();
    s_valid = 1'b1;
    s_data  = {16'h7FFF, 16'h8001};
    step();
    s_data = 32'h0012_3456;
    step();
    s_valid = 1'b0;
    wait_stb(3, 40, found);
    n_total++;
    if (!found || w_word !== {24'h7FFF00, 24'h800100})
      $display("FAIL widen_16_24: got found=%b word=%h expected 1/7fff00800100", found, w_word);
    else n_pass++;
    n_total++;
    if (n_stb !== 1'b1 || n_word !== 16'hFF80)
      $display("FAIL narrow_neg: got stb=%b word=%h expected 1/ff80", n_stb, n_word);
    else n_pass++;
    wait_stb(3, 40, found);
    n_total++;
    if (!found || w_word !== {24'h001200, 24'h345600})
      $display("FAIL widen_second: got found=%b word=%h expected 1/001200345600", found, w_word);
    else n_pass++;
    n_total++;
    if (n_word !== 16'h1234) $display("FAIL narrow_24_16: got %h expected 1234", n_word);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit found;
    apply_reset();
    repeat (7) step();
    s_valid = 1'b1;
    s_data  = 32'hAAAA_0001;
    step();
    n_total++;
    if (z_stb !== 1'b1 || z_underrun !== 1'b1 || z_word !== 32'h0 || z_level !== 4'd1)
      $display("FAIL empty_push_pop: got stb=%b ur=%b word=%h level=%0d expected 1/1/0/1",
               z_stb, z_underrun, z_word, z_level);
    else n_pass++;
    s_data = 32'hBBBB_0002;
    step();
    s_valid = 1'b0;
    n_total++;
    if (z_level !== 4'd2) $display("FAIL b2b_fill: got level=%0d expected 2", z_level);
    else n_pass++;
    repeat (6) step();
    s_valid = 1'b1;
    s_data  = 32'hCCCC_0003;
    step();
    s_valid = 1'b0;
    n_total++;
    if (z_stb !== 1'b1 || z_word !== 32'hAAAA_0001 || z_level !== 4'd2)
      $display("FAIL b2b_push_pop: got stb=%b word=%h level=%0d expected 1/aaaa0001/2",
               z_stb, z_word, z_level);
    else n_pass++;
    wait_stb(2, 40, found);
    n_total++;
    if (!found || z_word !== 32'hBBBB_0002 || z_level !== 4'd1)
      $display("FAIL b2b_order: got found=%b word=%h level=%0d expected 1/bbbb0002/1",
               found, z_word, z_level);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    s_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      s_data = 32'h5000_0000 + 32'(k);
      step();
    end
    s_valid = 1'b0;
    repeat (794) step();
    n_total++;
    if (d_level !== 4'd5 || d_clk !== 1'b1 || d_word !== 32'h5000_0001)
      $display("FAIL pre_reset: got level=%0d clk=%b word=%h expected 5/1/50000001",
               d_level, d_clk, d_word);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({d_clk, d_stb, d_underrun, d_ready, d_level} !== 8'b0001_0000 || d_word !== 32'h0)
      $display("FAIL async_reset: got %b/%h expected 00010000/0",
               {d_clk, d_stb, d_underrun, d_ready, d_level}, d_word);
    else n_pass++;
    #3;
    reset_n = 1'b1;
    repeat (262) step();
    n_total++;
    if (d_clk !== 1'b0) $display("FAIL restart_early: got clk_audio=%b expected 0", d_clk);
    else n_pass++;
    step();
    n_total++;
    if (d_clk !== 1'b1) $display("FAIL restart_tick: got clk_audio=%b expected 1", d_clk);
    else n_pass++;
  endtask

`ifdef HDMI_AUDIO_ATTEN_EN
  task automatic test_atten();
    bit found;
    atten_shift = 3'd2;
    apply_reset();
    s_valid = 1'b1;
    s_data  = {16'h8000, 16'h7FFF};
    repeat (2) step();
    s_valid = 1'b0;
    wait_stb(2, 40, found);
    n_total++;
    if (!found || z_word !== {16'hE000, 16'h1FFF})
      $display("FAIL atten_shift2: got found=%b word=%h expected 1/e0001fff", found, z_word);
    else n_pass++;
    atten_shift = 3'd0;
    step();
    n_total++;
    if (z_word !== {16'hE000, 16'h1FFF})
      $display("FAIL atten_hold: got %h expected e0001fff", z_word);
    else n_pass++;
    wait_stb(2, 40, found);
    n_total++;
    if (!found || z_word !== {16'h8000, 16'h7FFF})
      $display("FAIL atten_next_pop: got found=%b word=%h expected 1/80007fff", found, z_word);
    else n_pass++;
  endtask
`endif

  initial begin
`ifdef HDMI_AUDIO_ATTEN_EN
    atten_shift = 3'd0;
`endif
    test_reset();
    test_rate();
    test_fifo_full();
    test_underrun();
    test_width();
    test_back_to_back();
    test_async_reset();
`ifdef HDMI_AUDIO_ATTEN_EN
    test_atten();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
